// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU register-file access path: FSM encoding,
// default widths and instruction field positions.
package cpu_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

  localparam int ZERO_REG = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_HOLD  = 2'd3
  } gpr_state_e;

endpackage

// File: rtl/gpr_operand_latch.sv
// Capture register for operands A/B: r0 reads as zero, and a write issued in
// the same cycle as the read is forwarded into the captured value.
module gpr_operand_latch
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              capture,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [DATA_W-1:0] gpr_a,
  input  logic [DATA_W-1:0] gpr_b,
  input  logic              fwd_en,
  input  logic [ADDR_W-1:0] fwd_num,
  input  logic [DATA_W-1:0] fwd_data,
  output logic [DATA_W-1:0] opr_a,
  output logic [DATA_W-1:0] opr_b
);

  logic [DATA_W-1:0] opr_a_q, opr_a_d;
  logic [DATA_W-1:0] opr_b_q, opr_b_d;

  function automatic logic [DATA_W-1:0] pick(
    input logic [ADDR_W-1:0] idx,
    input logic [DATA_W-1:0] rd,
    input logic              f_en,
    input logic [ADDR_W-1:0] f_num,
    input logic [DATA_W-1:0] f_data
  );
    if (idx == ADDR_W'(ZERO_REG)) return '0;
    if (f_en && (idx == f_num))   return f_data;
    return rd;
  endfunction

  always_comb begin
    opr_a_d = opr_a_q;
    opr_b_d = opr_b_q;
    if (capture) begin
      opr_a_d = pick(rs, gpr_a, fwd_en, fwd_num, fwd_data);
      opr_b_d = pick(rt, gpr_b, fwd_en, fwd_num, fwd_data);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      opr_a_q <= '0;
      opr_b_q <= '0;
    end else begin
      opr_a_q <= opr_a_d;
      opr_b_q <= opr_b_d;
    end
  end

  assign opr_a = opr_a_q;
  assign opr_b = opr_b_q;

endmodule

// File: rtl/gpr_access_ctrl.sv
// Sequences decode reads and writeback writes onto the single register-file
// port. Optional GPR_DUAL_EN lets a write and a read share one READ cycle.
module gpr_access_ctrl
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [31:0]       dec_instr,
  output logic              opr_valid,
  input  logic              opr_ready,
  output logic [DATA_W-1:0] opr_a,
  output logic [DATA_W-1:0] opr_b,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_num,
  input  logic [DATA_W-1:0] wb_data,
  output logic [ADDR_W-1:0] gpr_rs,
  output logic [ADDR_W-1:0] gpr_rt,
  input  logic [DATA_W-1:0] gpr_a,
  input  logic [DATA_W-1:0] gpr_b,
  output logic              gpr_reg_write,
  output logic [ADDR_W-1:0] gpr_num_write,
  output logic [DATA_W-1:0] gpr_data_write
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; readies are forced low while reset_n is asserted.
  gpr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] rs_q, rs_d, rt_q, rt_d;
  logic [ADDR_W-1:0] wnum_q, wnum_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wpend_q, wpend_d;
  logic              capture;
  logic              unused_instr;

  assign unused_instr = ^{dec_instr[31:26], dec_instr[15:0]};

  always_comb begin
    state_d        = state_q;
    rs_d           = rs_q;
    rt_d           = rt_q;
    wnum_d         = wnum_q;
    wdata_d        = wdata_q;
    wpend_d        = wpend_q;
    dec_ready      = 1'b0;
    wb_ready       = 1'b0;
    opr_valid      = 1'b0;
    gpr_rs         = '0;
    gpr_rt         = '0;
    gpr_reg_write  = 1'b0;
    gpr_num_write  = '0;
    gpr_data_write = '0;
    capture        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        wb_ready = reset_n;
`ifdef GPR_DUAL_EN
        dec_ready = reset_n;
`else
        dec_ready = reset_n & ~wb_valid;
`endif
        if (wb_valid && wb_ready) begin
          wnum_d  = wb_num;
          wdata_d = wb_data;
          state_d = ST_WRITE;
        end
        // Only reachable together with a write when dual issue is enabled.
        if (dec_valid && dec_ready) begin
          rs_d    = ADDR_W'(dec_instr[RS_MSB:RS_LSB]);
          rt_d    = ADDR_W'(dec_instr[RT_MSB:RT_LSB]);
          wpend_d = wb_valid;
          state_d = ST_READ;
        end
      end
      ST_WRITE: begin
        gpr_reg_write  = (wnum_q != ADDR_W'(ZERO_REG));
        gpr_num_write  = wnum_q;
        gpr_data_write = wdata_q;
        state_d        = ST_IDLE;
      end
      ST_READ: begin
        gpr_rs  = rs_q;
        gpr_rt  = rt_q;
        capture = 1'b1;
        if (wpend_q) begin
          gpr_reg_write  = (wnum_q != ADDR_W'(ZERO_REG));
          gpr_num_write  = wnum_q;
          gpr_data_write = wdata_q;
        end
        wpend_d = 1'b0;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        opr_valid = 1'b1;
        if (opr_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      rs_q    <= '0;
      rt_q    <= '0;
      wnum_q  <= '0;
      wdata_q <= '0;
      wpend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      wnum_q  <= wnum_d;
      wdata_q <= wdata_d;
      wpend_q <= wpend_d;
    end
  end

  gpr_operand_latch #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_operand_latch (
    .clock   (clock),
    .reset_n (reset_n),
    .capture (capture),
    .rs      (rs_q),
    .rt      (rt_q),
    .gpr_a   (gpr_a),
    .gpr_b   (gpr_b),
    .fwd_en  (wpend_q),
    .fwd_num (wnum_q),
    .fwd_data(wdata_q),
    .opr_a   (opr_a),
    .opr_b   (opr_b)
  );

endmodule

// File: tb/tb_gpr_access_ctrl.sv
// Bench for gpr_access_ctrl: table-driven reads, directed corner sequences and
// a randomized mix checked against an array-based register-file model.
module tb_gpr_access_ctrl;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          dec_valid, dec_ready;
  logic [31:0]   dec_instr;
  logic          opr_valid, opr_ready;
  logic [DW-1:0] opr_a, opr_b;
  logic          wb_valid, wb_ready;
  logic [AW-1:0] wb_num;
  logic [DW-1:0] wb_data;
  logic [AW-1:0] gpr_rs, gpr_rt;
  logic [DW-1:0] gpr_a, gpr_b;
  logic          gpr_reg_write;
  logic [AW-1:0] gpr_num_write;
  logic [DW-1:0] gpr_data_write;

  // Environment register file (written by DUT strobes) and reference model.
  logic [DW-1:0] rf [32]     = '{default: '0};
  logic [DW-1:0] ref_rf [32] = '{default: '0};
  logic          use_model;
  logic [DW-1:0] drv_a, drv_b;

  logic [63:0]   exp_q[$];
  logic [36:0]   exp_wr_q[$];
  int            total = 0;
  int            bad = 0;
  int            strobe_cnt = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] ga;
    logic [31:0] gb;
    logic [31:0] ea;
    logic [31:0] eb;
  } rd_vec_t;

  rd_vec_t tab [4];

  gpr_access_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .dec_valid     (dec_valid),
    .dec_ready     (dec_ready),
    .dec_instr     (dec_instr),
    .opr_valid     (opr_valid),
    .opr_ready     (opr_ready),
    .opr_a         (opr_a),
    .opr_b         (opr_b),
    .wb_valid      (wb_valid),
    .wb_ready      (wb_ready),
    .wb_num        (wb_num),
    .wb_data       (wb_data),
    .gpr_rs        (gpr_rs),
    .gpr_rt        (gpr_rt),
    .gpr_a         (gpr_a),
    .gpr_b         (gpr_b),
    .gpr_reg_write (gpr_reg_write),
    .gpr_num_write (gpr_num_write),
    .gpr_data_write(gpr_data_write)
  );

  // ---------------- clock / environment ----------------
  always #5 clock = ~clock;

  assign gpr_a = use_model ? rf[gpr_rs] : drv_a;
  assign gpr_b = use_model ? rf[gpr_rt] : drv_b;

  always @(posedge clock) begin
    if (gpr_reg_write && gpr_num_write != 0) rf[gpr_num_write] <= gpr_data_write;
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got no event within bound, want event", nm);
  endtask

  function automatic logic [31:0] refv(input logic [4:0] i);
    return (i == 0) ? 32'h0 : ref_rf[i];
  endfunction

  // Write strobe monitor: every strobe must match the next expected write.
  always @(negedge clock) begin
    if (reset_n && gpr_reg_write) begin
      logic [36:0] e;
      strobe_cnt++;
      if (exp_wr_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL strobe_unexpected: got num %0d, want no strobe", gpr_num_write);
      end else begin
        e = exp_wr_q.pop_front();
        chk("strobe_num", 32'(gpr_num_write), 32'(e[36:32]));
        chk("strobe_data", gpr_data_write, e[31:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_write(input logic [4:0] n, input logic [31:0] d);
    int k;
    wb_valid = 1'b1;
    wb_num   = n;
    wb_data  = d;
    for (k = 0; k < 20; k++) begin
      @(negedge clock);
      if (wb_ready) break;
    end
    if (k == 20) begin
      timeout("wb_handshake");
      wb_valid = 1'b0;
      return;
    end
    if (n != 0) begin
      ref_rf[n] = d;
      exp_wr_q.push_back({n, d});
    end
    @(posedge clock);
    #1 wb_valid = 1'b0;
    @(negedge clock);
    chk("wr_strobe", 32'(gpr_reg_write), 32'(n != 0));
    chk("wr_num", 32'(gpr_num_write), 32'(n));
    chk("wr_data", gpr_data_write, d);
  endtask

  task automatic send_dec(input logic [31:0] instr, output bit ok);
    int k;
    dec_valid = 1'b1;
    dec_instr = instr;
    ok = 1'b0;
    for (k = 0; k < 20; k++) begin
      @(negedge clock);
      if (dec_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      timeout("dec_handshake");
      dec_valid = 1'b0;
      return;
    end
    @(posedge clock);
    #1 dec_valid = 1'b0;
  endtask

  task automatic read_op(input logic [31:0] instr, output logic [31:0] a,
                         output logic [31:0] b, output bit got);
    bit ok;
    int lat;
    a = '0;
    b = '0;
    got = 1'b0;
    send_dec(instr, ok);
    if (!ok) return;
    @(negedge clock);
    chk("read_rs", 32'(gpr_rs), 32'(instr[25:21]));
    chk("read_rt", 32'(gpr_rt), 32'(instr[20:16]));
    chk("read_not_valid", 32'(opr_valid), 32'h0);
    lat = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      lat++;
      if (opr_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      timeout("opr_valid");
      return;
    end
    chk("opr_latency", 32'(lat), 32'd2);
    a = opr_a;
    b = opr_b;
  endtask

  task automatic take_opr();
    opr_ready = 1'b1;
    @(posedge clock);
    #1 opr_ready = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] a, b, instr;
    logic [63:0] e;
    bit          got;
    int          s0;

    tab[0] = '{32'h012A4020, 32'h11,       32'h22,       32'h11,       32'h22};
    tab[1] = '{32'h00030000, 32'h55,       32'h66,       32'h0,        32'h66};
    tab[2] = '{32'h03E00000, 32'hAAAA5555, 32'h77,       32'hAAAA5555, 32'h0};
    tab[3] = '{32'hFC00FFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0};

    reset_n   = 1'b0;
    dec_valid = 1'b0;
    dec_instr = '0;
    opr_ready = 1'b0;
    wb_valid  = 1'b0;
    wb_num    = '0;
    wb_data   = '0;
    use_model = 1'b0;
    drv_a     = '0;
    drv_b     = '0;

    #2;
    chk("rst_ready", {30'h0, dec_ready, wb_ready}, 32'h0);
    chk("rst_opr", {30'h0, opr_valid, gpr_reg_write}, 32'h0);
    chk("rst_opr_a", opr_a, 32'h0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    chk("idle_wb_ready", 32'(wb_ready), 32'h1);
    chk("idle_dec_ready", 32'(dec_ready), 32'h1);
    @(posedge clock);
    #1;

    // Table-driven reads with the register file data driven directly.
    for (int i = 0; i < 4; i++) begin
      drv_a = tab[i].ga;
      drv_b = tab[i].gb;
      read_op(tab[i].instr, a, b, got);
      if (got) begin
        chk("tab_opr_a", a, tab[i].ea);
        chk("tab_opr_b", b, tab[i].eb);
        take_opr();
      end
    end

    // Writes: normal register and r0 (no strobe, handshake still completes).
    use_model = 1'b1;
    s0 = strobe_cnt;
    do_write(5'd7, 32'hDEADBEEF);
    repeat (2) @(negedge clock);
    chk("one_strobe", 32'(strobe_cnt - s0), 32'd1);
    s0 = strobe_cnt;
    do_write(5'd0, 32'h0000FFFF);
    repeat (2) @(negedge clock);
    chk("r0_no_strobe", 32'(strobe_cnt - s0), 32'd0);
    @(posedge clock);
    #1;
    read_op(32'h00E00000, a, b, got);  // rs=7, rt=0
    if (got) begin
      chk("read_after_wr_a", a, 32'hDEADBEEF);
      chk("read_after_wr_b", b, 32'h0);
      take_opr();
    end

    // Simultaneous writeback and decode request in IDLE.
    do_write(5'd10, 32'h0A0A0A0A);
    @(posedge clock);
    #1;
    wb_valid  = 1'b1;
    wb_num    = 5'd9;
    wb_data   = 32'hCAFEF00D;
    dec_valid = 1'b1;
    dec_instr = 32'h012A4020;
    @(negedge clock);
    chk("sim_wb_ready", 32'(wb_ready), 32'h1);
`ifdef GPR_DUAL_EN
    chk("sim_dec_ready", 32'(dec_ready), 32'h1);
`else
    chk("sim_dec_ready", 32'(dec_ready), 32'h0);
`endif
    ref_rf[9] = 32'hCAFEF00D;
    exp_wr_q.push_back({5'd9, 32'hCAFEF00D});
    @(posedge clock);
    #1 wb_valid = 1'b0;
`ifdef GPR_DUAL_EN
    dec_valid = 1'b0;
`else
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (dec_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) timeout("sim_dec_handshake");
    @(posedge clock);
    #1 dec_valid = 1'b0;
`endif
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (opr_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) timeout("sim_opr_valid");
    else begin
      chk("sim_opr_a", opr_a, 32'hCAFEF00D);
      chk("sim_opr_b", opr_b, 32'h0A0A0A0A);
      take_opr();
    end

    // Back-pressure: operands held stable, both readies low.
    use_model = 1'b0;
    drv_a = 32'h11;
    drv_b = 32'h22;
    read_op(32'h012A4020, a, b, got);
    if (got) begin
      drv_a = 32'h99;
      drv_b = 32'h98;
      repeat (5) begin
        @(negedge clock);
        chk("bp_valid", 32'(opr_valid), 32'h1);
        chk("bp_opr_a", opr_a, 32'h11);
        chk("bp_opr_b", opr_b, 32'h22);
        chk("bp_readies", {30'h0, dec_ready, wb_ready}, 32'h0);
      end
      take_opr();
      @(negedge clock);
      chk("bp_release_valid", 32'(opr_valid), 32'h0);
      chk("bp_release_wb_ready", 32'(wb_ready), 32'h1);
    end

    // Reset during HOLD.
    @(posedge clock);
    #1;
    read_op(32'h012A4020, a, b, got);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_hold_valid", 32'(opr_valid), 32'h0);
    chk("rst_hold_a", opr_a, 32'h0);
    chk("rst_hold_b", opr_b, 32'h0);
    chk("rst_hold_ready", {30'h0, dec_ready, wb_ready}, 32'h0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    chk("rst_hold_after", 32'(opr_valid), 32'h0);

    // Reset during WRITE: the pending write is discarded.
    use_model = 1'b1;
    @(posedge clock);
    #1;
    wb_valid = 1'b1;
    wb_num   = 5'd5;
    wb_data  = 32'h0BADBAD0;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (wb_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) timeout("rst_wr_handshake");
    @(posedge clock);
    #1 wb_valid = 1'b0;
    chk("rst_wr_before", 32'(gpr_reg_write), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("rst_wr_strobe", 32'(gpr_reg_write), 32'h0);
    chk("rst_wr_num", 32'(gpr_num_write), 32'h0);
    chk("rst_wr_data", gpr_data_write, 32'h0);
    s0 = strobe_cnt;
    @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (4) @(negedge clock);
    chk("rst_wr_no_strobe", 32'(strobe_cnt - s0), 32'h0);
    @(posedge clock);
    #1;

    // Randomized mix against the reference register file.
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        do_write(5'($urandom_range(0, 31)), $urandom);
        @(posedge clock);
        #1;
      end else begin
        instr = $urandom;
        exp_q.push_back({refv(instr[25:21]), refv(instr[20:16])});
        read_op(instr, a, b, got);
        if (got) begin
          e = exp_q.pop_front();
          chk("rnd_opr_a", a, e[63:32]);
          chk("rnd_opr_b", b, e[31:0]);
          repeat ($urandom_range(0, 3)) @(negedge clock);
          take_opr();
        end
      end
    end

    repeat (3) @(negedge clock);
    chk("wr_queue_empty", 32'(exp_wr_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish within time limit, want finish");
    $fatal(1, "time limit");
  end

endmodule
